p_hit_seq: RTL and testbench

- Parametrised successor to the dual-ray p_hit datapath.
- Computes the ray/plane hit point for a single ray stream: p = o + t*d, with t = dot(n, v0-o) / dot(n, d), in signed Q fixed point.
- Uses an iterative bit-serial divider under an FSM. Input is buffered in a request FIFO, results in a result FIFO.
- Adds a hit/miss flag, optional back-face culling and a miss counter. Sits between ray generation and the barycentric inside-test.

---
 rtl/p_hit_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_p_hit_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/p_hit_seq.sv
// Ray/plane hit point p = o + t*d in signed Q fixed point, t from a restoring bit-serial divider.
// One ray per NDIV+4 cycles (4 when den == 0); a full result FIFO stalls WRITE, requests back up to in_full.

module p_hit_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   output logic         full,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = rd_en && !empty;
   assign do_push = wr_en && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW+1)'(1);
         else if (do_pop && !do_push) count <= count - (AW+1)'(1);
      end
   end
endmodule

module p_hit_seq #(
   parameter int D_BITS        = 40,
   parameter int Q_BITS        = 16,
   parameter int IN_DEPTH      = 4,
   parameter int OUT_DEPTH     = 4,
   parameter int CULL_BACKFACE = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_wr_en,
   output logic                in_full,
   input  logic [3*D_BITS-1:0] in_origin,
   input  logic [3*D_BITS-1:0] in_dir,
   input  logic [3*D_BITS-1:0] in_normal,
   input  logic [3*D_BITS-1:0] in_v0,
   input  logic                out_rd_en,
   output logic                out_empty,
   output logic [3*D_BITS-1:0] out_p,
   output logic [D_BITS-1:0]   out_t,
   output logic                out_hit,
   output logic [15:0]         out_miss_count
);
   localparam int NDIV = D_BITS + Q_BITS;
   localparam int CW   = $clog2(NDIV);
   localparam int RW   = 12 * D_BITS;
   localparam int OW   = 4 * D_BITS + 1;
   localparam logic [NDIV-1:0] QMAX = (NDIV'(1) << (D_BITS - 1)) - NDIV'(1);

   typedef enum logic [2:0] {IDLE, DOT, DIV, MUL, WRITE} state_t;
   state_t state, state_nx;

   logic                       req_pop, req_empty, res_push, res_full;
   logic [RW-1:0]              req_data, ray;
   logic [OW-1:0]              res_data;
   logic signed [D_BITS-1:0]   o_v [3];
   logic signed [D_BITS-1:0]   d_v [3];
   logic signed [D_BITS-1:0]   n_v [3];
   logic signed [D_BITS-1:0]   v_v [3];
   logic signed [2*D_BITS+1:0] num_sum, den_sum;
   logic signed [D_BITS-1:0]   num_d, den_d, den, t_val;
   logic [D_BITS-1:0]          num_mag, den_mag_d, den_mag, rem, t_mag;
   logic [NDIV-1:0]            dq;
   logic [D_BITS:0]            shifted;
   logic                       ge, neg, hit_val, res_hit;
   logic [CW-1:0]              cnt;
   logic [3*D_BITS-1:0]        p_val, res_p;
   logic [D_BITS-1:0]          res_t;
   logic [15:0]                miss_cnt;

   function automatic logic signed [2*D_BITS-1:0] mul(input logic signed [D_BITS-1:0] a,
                                                      input logic signed [D_BITS-1:0] b);
      logic signed [2*D_BITS-1:0] ae, be;
      ae = {{D_BITS{a[D_BITS-1]}}, a};
      be = {{D_BITS{b[D_BITS-1]}}, b};
      return ae * be;
   endfunction

   p_hit_fifo #(.W(RW), .DEPTH(IN_DEPTH)) u_req (
      .clock(clock), .reset(reset),
      .wr_en(in_wr_en), .wr_data({in_v0, in_normal, in_dir, in_origin}), .full(in_full),
      .rd_en(req_pop), .rd_data(req_data), .empty(req_empty)
   );

   p_hit_fifo #(.W(OW), .DEPTH(OUT_DEPTH)) u_res (
      .clock(clock), .reset(reset),
      .wr_en(res_push), .wr_data({res_hit, res_t, res_p}), .full(res_full),
      .rd_en(out_rd_en), .rd_data(res_data), .empty(out_empty)
   );

   for (genvar i = 0; i < 3; i++) begin : g_axis
      assign o_v[i] = ray[i*D_BITS +: D_BITS];
      assign d_v[i] = ray[3*D_BITS + i*D_BITS +: D_BITS];
      assign n_v[i] = ray[6*D_BITS + i*D_BITS +: D_BITS];
      assign v_v[i] = ray[9*D_BITS + i*D_BITS +: D_BITS];
      assign p_val[i*D_BITS +: D_BITS] = o_v[i] + D_BITS'(mul(t_val, d_v[i]) >>> Q_BITS);
   end

   // Products summed with two guard bits, then scaled back and wrapped to D_BITS.
   always_comb begin
      num_sum = '0;
      den_sum = '0;
      for (int i = 0; i < 3; i++) begin
         num_sum = num_sum + (2*D_BITS+2)'(mul(n_v[i], v_v[i] - o_v[i]));
         den_sum = den_sum + (2*D_BITS+2)'(mul(n_v[i], d_v[i]));
      end
      num_d     = D_BITS'(num_sum >>> Q_BITS);
      den_d     = D_BITS'(den_sum >>> Q_BITS);
      num_mag   = num_d[D_BITS-1] ? D_BITS'(-num_d) : num_d;
      den_mag_d = den_d[D_BITS-1] ? D_BITS'(-den_d) : den_d;
   end

   assign shifted = {rem, dq[NDIV-1]};
   assign ge      = (shifted >= {1'b0, den_mag});

   always_comb begin
      t_mag = (dq > QMAX) ? QMAX[D_BITS-1:0] : dq[D_BITS-1:0];
      if (den == '0)  t_val = '0;
      else if (neg)   t_val = -t_mag;
      else            t_val = t_mag;
      hit_val = (den != '0) && !t_val[D_BITS-1] &&
                !((CULL_BACKFACE != 0) && !den[D_BITS-1]);
   end

   always_comb begin
      state_nx = state;
      req_pop  = 1'b0;
      res_push = 1'b0;
      case (state)
         IDLE:  if (!req_empty) begin
                   req_pop  = 1'b1;
                   state_nx = DOT;
                end
         DOT:   state_nx = (den_d == '0) ? MUL : DIV;
         DIV:   if (cnt == CW'(NDIV - 1)) state_nx = MUL;
         MUL:   state_nx = WRITE;
         WRITE: if (!res_full || out_rd_en) begin
                   res_push = 1'b1;
                   state_nx = IDLE;
                end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ray      <= '0;
         den      <= '0;
         den_mag  <= '0;
         neg      <= 1'b0;
         dq       <= '0;
         rem      <= '0;
         cnt      <= '0;
         res_p    <= '0;
         res_t    <= '0;
         res_hit  <= 1'b0;
         miss_cnt <= '0;
      end else begin
         case (state)
            IDLE:  if (req_pop) ray <= req_data;
            DOT: begin
               den     <= den_d;
               den_mag <= den_mag_d;
               neg     <= num_d[D_BITS-1] ^ den_d[D_BITS-1];
               dq      <= {num_mag, {Q_BITS{1'b0}}};
               rem     <= '0;
               cnt     <= '0;
            end
            // dq shifts dividend bits out the top and quotient bits in the bottom.
            DIV: begin
               rem <= ge ? D_BITS'(shifted - {1'b0, den_mag}) : shifted[D_BITS-1:0];
               dq  <= {dq[NDIV-2:0], ge};
               cnt <= cnt + CW'(1);
            end
            MUL: begin
               res_p   <= p_val;
               res_t   <= t_val;
               res_hit <= hit_val;
            end
            WRITE: if (res_push && !res_hit) miss_cnt <= miss_cnt + 16'd1;
            default: ;
         endcase
      end
   end

   assign out_p          = res_data[3*D_BITS-1:0];
   assign out_t          = res_data[4*D_BITS-1:3*D_BITS];
   assign out_hit        = res_data[4*D_BITS];
   assign out_miss_count = miss_cnt;
endmodule

// File: tb/tb_p_hit_seq.sv
// Directed bench for p_hit_seq: default instance plus a back-face-culling instance on shared operand buses.
module tb_p_hit_seq;
   localparam int D = 40;
   localparam logic [D-1:0] ZERO = 40'h00_0000_0000;
   localparam logic [D-1:0] ONE  = 40'h00_0001_0000;
   localparam logic [D-1:0] TEN  = 40'h00_000A_0000;
   localparam logic [D-1:0] MTEN = 40'hFF_FFF6_0000;
   localparam logic [D-1:0] MONE = 40'hFF_FFFF_0000;

   logic clock = 1'b0;
   logic reset;
   logic a_wr_en, a_rd_en, b_wr_en, b_rd_en;
   logic [3*D-1:0] origin, dir, normal, v0;
   logic a_in_full, a_out_empty, a_out_hit, b_in_full, b_out_empty, b_out_hit;
   logic [3*D-1:0] a_out_p, b_out_p;
   logic [D-1:0] a_out_t, b_out_t;
   logic [15:0] a_miss, b_miss;
   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   p_hit_seq dut_a (
      .clock(clock), .reset(reset), .in_wr_en(a_wr_en), .in_full(a_in_full),
      .in_origin(origin), .in_dir(dir), .in_normal(normal), .in_v0(v0),
      .out_rd_en(a_rd_en), .out_empty(a_out_empty), .out_p(a_out_p), .out_t(a_out_t),
      .out_hit(a_out_hit), .out_miss_count(a_miss)
   );

   p_hit_seq #(.CULL_BACKFACE(1)) dut_b (
      .clock(clock), .reset(reset), .in_wr_en(b_wr_en), .in_full(b_in_full),
      .in_origin(origin), .in_dir(dir), .in_normal(normal), .in_v0(v0),
      .out_rd_en(b_rd_en), .out_empty(b_out_empty), .out_p(b_out_p), .out_t(b_out_t),
      .out_hit(b_out_hit), .out_miss_count(b_miss)
   );

   function automatic logic [3*D-1:0] vec3(input logic [D-1:0] x, input logic [D-1:0] y,
                                           input logic [D-1:0] z);
      return {z, y, x};
   endfunction

   task automatic set_ray(input logic [3*D-1:0] o, input logic [3*D-1:0] d,
                          input logic [3*D-1:0] n, input logic [3*D-1:0] v);
      origin = o; dir = d; normal = n; v0 = v;
   endtask

   task automatic push(input bit on_b);
      @(negedge clock);
      if (on_b) b_wr_en = 1'b1; else a_wr_en = 1'b1;
      @(posedge clock);
      #1;
      a_wr_en = 1'b0; b_wr_en = 1'b0;
   endtask

   task automatic pop(input bit on_b);
      @(negedge clock);
      if (on_b) b_rd_en = 1'b1; else a_rd_en = 1'b1;
      @(posedge clock);
      #1;
      a_rd_en = 1'b0; b_rd_en = 1'b0;
   endtask

   task automatic wait_out(input bit on_b, output int lat);
      lat = 0;
      while ((on_b ? b_out_empty : a_out_empty) && lat < 200) begin
         @(posedge clock);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      #1;
      checks++; if (a_in_full !== 1'b0) begin failures++; $display("FAIL rst_in_full got %b exp 0", a_in_full); end
      checks++; if (a_out_empty !== 1'b1) begin failures++; $display("FAIL rst_out_empty got %b exp 1", a_out_empty); end
      checks++; if (a_out_p !== '0) begin failures++; $display("FAIL rst_out_p got %h exp 0", a_out_p); end
      checks++; if (a_out_t !== ZERO) begin failures++; $display("FAIL rst_out_t got %h exp 0", a_out_t); end
      checks++; if (a_out_hit !== 1'b0) begin failures++; $display("FAIL rst_out_hit got %b exp 0", a_out_hit); end
      checks++; if (a_miss !== 16'd0) begin failures++; $display("FAIL rst_miss got %0d exp 0", a_miss); end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (b_out_empty !== 1'b1 || b_in_full !== 1'b0) begin
         failures++; $display("FAIL rst_b_flags got empty=%b full=%b exp 1/0", b_out_empty, b_in_full);
      end
   endtask

   task automatic test_basic_hit();
      int lat;
      set_ray('0, vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, TEN));
      push(1'b0);
      wait_out(1'b0, lat);
      checks++; if (lat != 60) begin failures++; $display("FAIL basic_latency got %0d exp 60", lat); end
      checks++; if (a_out_t !== TEN) begin failures++; $display("FAIL basic_t got %h exp %h", a_out_t, TEN); end
      checks++; if (a_out_p !== vec3(ZERO, ZERO, TEN)) begin failures++; $display("FAIL basic_p got %h", a_out_p); end
      checks++; if (a_out_hit !== 1'b1) begin failures++; $display("FAIL basic_hit got %b exp 1", a_out_hit); end
      pop(1'b0);
      checks++; if (a_out_empty !== 1'b1) begin failures++; $display("FAIL basic_drained got %b exp 1", a_out_empty); end
   endtask

   task automatic test_oblique();
      int lat;
      set_ray('0, vec3(ONE, ZERO, ONE), vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, TEN));
      push(1'b0);
      wait_out(1'b0, lat);
      checks++; if (a_out_t !== TEN) begin failures++; $display("FAIL oblique_t got %h exp %h", a_out_t, TEN); end
      checks++; if (a_out_p !== vec3(TEN, ZERO, TEN)) begin failures++; $display("FAIL oblique_p got %h", a_out_p); end
      checks++; if (a_out_hit !== 1'b1) begin failures++; $display("FAIL oblique_hit got %b exp 1", a_out_hit); end
      pop(1'b0);
   endtask

   task automatic test_parallel();
      int lat;
      logic [3*D-1:0] o;
      o = vec3(40'h3_0000, 40'h2_0000, 40'h1_0000);
      set_ray(o, vec3(ONE, ZERO, ZERO), vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, TEN));
      push(1'b0);
      wait_out(1'b0, lat);
      checks++; if (lat != 4) begin failures++; $display("FAIL parallel_latency got %0d exp 4", lat); end
      checks++; if (a_out_t !== ZERO) begin failures++; $display("FAIL parallel_t got %h exp 0", a_out_t); end
      checks++; if (a_out_p !== o) begin failures++; $display("FAIL parallel_p got %h exp %h", a_out_p, o); end
      checks++; if (a_out_hit !== 1'b0) begin failures++; $display("FAIL parallel_hit got %b exp 0", a_out_hit); end
      checks++; if (a_miss !== 16'd1) begin failures++; $display("FAIL parallel_miss got %0d exp 1", a_miss); end
      pop(1'b0);
   endtask

   task automatic test_behind();
      int lat;
      set_ray('0, vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, MTEN));
      push(1'b0);
      wait_out(1'b0, lat);
      checks++; if (a_out_t !== MTEN) begin failures++; $display("FAIL behind_t got %h exp %h", a_out_t, MTEN); end
      checks++; if (a_out_p !== vec3(ZERO, ZERO, MTEN)) begin failures++; $display("FAIL behind_p got %h", a_out_p); end
      checks++; if (a_out_hit !== 1'b0) begin failures++; $display("FAIL behind_hit got %b exp 0", a_out_hit); end
      checks++; if (a_miss !== 16'd2) begin failures++; $display("FAIL behind_miss got %0d exp 2", a_miss); end
      pop(1'b0);
   endtask

   task automatic test_cull();
      int lat;
      set_ray('0, vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, TEN));
      push(1'b1);
      wait_out(1'b1, lat);
      checks++; if (b_out_t !== TEN) begin failures++; $display("FAIL cull_front_t got %h exp %h", b_out_t, TEN); end
      checks++; if (b_out_hit !== 1'b0) begin failures++; $display("FAIL cull_front_hit got %b exp 0", b_out_hit); end
      pop(1'b1);
      set_ray('0, vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, MONE), vec3(ZERO, ZERO, TEN));
      push(1'b1);
      wait_out(1'b1, lat);
      checks++; if (b_out_t !== TEN) begin failures++; $display("FAIL cull_back_t got %h exp %h", b_out_t, TEN); end
      checks++; if (b_out_p !== vec3(ZERO, ZERO, TEN)) begin failures++; $display("FAIL cull_back_p got %h", b_out_p); end
      checks++; if (b_out_hit !== 1'b1) begin failures++; $display("FAIL cull_back_hit got %b exp 1", b_out_hit); end
      checks++; if (b_miss !== 16'd1) begin failures++; $display("FAIL cull_miss got %0d exp 1", b_miss); end
      pop(1'b1);
   endtask

   // Rays k=0..8 along +z to plane z=(k+1), plane mirrored behind the origin for odd k.
   task automatic test_back_to_back();
      int accepted;
      int lat;
      int w;
      logic [D-1:0] ez;
      logic [160:0] exp_res;
      accepted = 0;
      for (int k = 0; k < 9; k++) begin
         ez = D'((k + 1) * 65536);
         if (k % 2 == 1) ez = -ez;
         set_ray('0, vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, ez));
         @(negedge clock);
         w = 0;
         while (a_in_full && w < 500) begin @(negedge clock); w++; end
         if (!a_in_full) begin
            a_wr_en = 1'b1;
            @(posedge clock);
            #1;
            a_wr_en = 1'b0;
            accepted++;
         end
      end
      checks++; if (accepted != 9) begin failures++; $display("FAIL bp_accepted got %0d exp 9", accepted); end
      repeat (360) @(posedge clock);
      #1;
      checks++; if (a_in_full !== 1'b1) begin failures++; $display("FAIL bp_in_full got %b exp 1", a_in_full); end
      set_ray('0, vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, TEN));
      push(1'b0);
      for (int j = 0; j < 9; j++) begin
         ez = D'((j + 1) * 65536);
         if (j % 2 == 1) ez = -ez;
         exp_res = {(j % 2 == 0), ez, vec3(ZERO, ZERO, ez)};
         wait_out(1'b0, lat);
         checks++; if ({a_out_hit, a_out_t, a_out_p} !== exp_res) begin
            failures++; $display("FAIL bp_result_%0d got %h exp %h", j, {a_out_hit, a_out_t, a_out_p}, exp_res);
         end
         pop(1'b0);
      end
      repeat (200) @(posedge clock);
      #1;
      checks++; if (a_out_empty !== 1'b1) begin failures++; $display("FAIL bp_extra_result got empty=%b exp 1", a_out_empty); end
      checks++; if (a_miss !== 16'd6) begin failures++; $display("FAIL bp_miss got %0d exp 6", a_miss); end
   endtask

   task automatic test_reset_mid_div();
      set_ray('0, vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, ONE), vec3(ZERO, ZERO, MTEN));
      push(1'b0);
      push(1'b0);
      repeat (10) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++; if (a_out_empty !== 1'b1) begin failures++; $display("FAIL rdiv_empty got %b exp 1", a_out_empty); end
      checks++; if (a_miss !== 16'd0) begin failures++; $display("FAIL rdiv_miss got %0d exp 0", a_miss); end
      checks++; if (a_in_full !== 1'b0) begin failures++; $display("FAIL rdiv_in_full got %b exp 0", a_in_full); end
      reset = 1'b0;
      repeat (150) @(posedge clock);
      #1;
      checks++; if (a_out_empty !== 1'b1) begin failures++; $display("FAIL rdiv_spurious got empty=%b exp 1", a_out_empty); end
      checks++; if (a_miss !== 16'd0) begin failures++; $display("FAIL rdiv_miss_after got %0d exp 0", a_miss); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      a_wr_en = 1'b0; a_rd_en = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
      origin = '0; dir = '0; normal = '0; v0 = '0;
      test_reset();
      test_basic_hit();
      test_oblique();
      test_parallel();
      test_behind();
      test_cull();
      test_back_to_back();
      test_reset_mid_div();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
